// File: rtl/mem_io_responder.sv
// Byte-wide memory bus responder: RAM, a read-as-zero hole, and an I/O window
// with UART TX FIFO, RX pop, a 32-bit cycle counter snapshot and a sticky program stop.
module mem_io_responder #(
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned FULL_MARGIN = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_din,
  input  logic        mem_wr,
  output logic [7:0]  mem_dout,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop
);

  localparam int unsigned PtrW = $clog2(TX_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt  = CntW'(TX_DEPTH);
  localparam logic [CntW-1:0] FullLevel = CntW'(TX_DEPTH - FULL_MARGIN);

  logic [7:0]      ram_q [2**ADDR_WIDTH];
  logic [7:0]      ram_rdata_q;
  logic            sel_ram_q, sel_ram_d;
  logic [7:0]      io_dout_q, io_dout_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     snap_q, snap_d;
  logic            stop_q, stop_d;
  logic            full_q, full_d;
  logic [7:0]      fifo_q [TX_DEPTH];
  logic [7:0]      fifo_d [TX_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            is_ram, is_io, ram_we;
  logic [2:0]      io_off;
  logic            push_req, push_ok, pop;
  logic [7:0]      push_data;
  logic            unused_a;

  assign is_ram   = ~mem_a[17];
  assign is_io    = (mem_a[17:16] == 2'b11);
  assign io_off   = mem_a[2:0];
  assign ram_we   = ~rst_in & mem_wr & is_ram;
  assign unused_a = ^mem_a[31:18];

  // RAM storage has no reset; contents survive rst_in.
  always_ff @(posedge clk_in) begin
    if (ram_we) ram_q[mem_a[ADDR_WIDTH-1:0]] <= mem_din;
    ram_rdata_q <= ram_q[mem_a[ADDR_WIDTH-1:0]];
  end

  always_comb begin
    rx_ready  = 1'b0;
    io_dout_d = 8'h00;
    sel_ram_d = 1'b0;
    snap_d    = snap_q;
    stop_d    = stop_q;
    push_req  = 1'b0;
    push_data = mem_din;
    if (!rst_in) begin
      if (mem_wr) begin
        if (is_io) begin
          case (io_off)
            3'd0: push_req = (mem_din != 8'h00);
            3'd4: begin
              push_req  = 1'b1;
              push_data = 8'h00;
              stop_d    = 1'b1;
            end
            default: ;
          endcase
        end
      end else begin
        sel_ram_d = is_ram;
        if (is_io) begin
          case (io_off)
            3'd0: if (rx_valid) begin
              rx_ready  = 1'b1;
              io_dout_d = rx_data;
            end
            3'd4: begin
              io_dout_d = cnt_q[7:0];
              snap_d    = cnt_q;
            end
            3'd5:    io_dout_d = snap_q[15:8];
            3'd6:    io_dout_d = snap_q[23:16];
            3'd7:    io_dout_d = snap_q[31:24];
            default: ;
          endcase
        end
      end
    end
  end

  // Push acceptance looks at the occupancy before this cycle's pop.
  always_comb begin
    pop      = tx_valid & tx_ready;
    push_ok  = push_req & (count_q < DepthCnt);
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      fifo_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + PtrW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    count_d = count_q + CntW'(push_ok) - CntW'(pop);
    full_d  = (count_d >= FullLevel);
    cnt_d   = cnt_q + 32'(rdy_in);
  end

  always_ff @(posedge clk_in) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel_ram_q <= 1'b0;
      io_dout_q <= 8'h00;
      cnt_q     <= '0;
      snap_q    <= '0;
      stop_q    <= 1'b0;
      full_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      sel_ram_q <= sel_ram_d;
      io_dout_q <= io_dout_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      stop_q    <= stop_d;
      full_q    <= full_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign mem_dout       = sel_ram_q ? ram_rdata_q : io_dout_q;
  assign io_buffer_full = full_q;
  assign program_stop   = stop_q;
  assign tx_valid       = (count_q != '0);
  assign tx_data        = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: a driver updates a behavioural model and
// queues expectations; a negedge monitor compares DUT outputs against them.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] a = 32'h0002_0000;
  logic [7:0]  din = 8'h00;
  logic        wr = 1'b0;
  logic [7:0]  dout;
  logic        full;
  logic [7:0]  txd;
  logic        txv;
  logic        txr = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        rxv = 1'b0;
  logic        rxr;
  logic        stop;

  always #5 clk = ~clk;

  mem_io_responder dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .rdy_in        (rdy),
    .mem_a         (a),
    .mem_din       (din),
    .mem_wr        (wr),
    .mem_dout      (dout),
    .io_buffer_full(full),
    .tx_data       (txd),
    .tx_valid      (txv),
    .tx_ready      (txr),
    .rx_data       (rxd),
    .rx_valid      (rxv),
    .rx_ready      (rxr),
    .program_stop  (stop)
  );

  typedef struct {
    logic       chk_dout;
    logic [7:0] dout;
    logic       full;
    logic       txv;
    logic       stop;
  } post_t;

  // Behavioural model state
  logic [7:0]  m_ram [int];
  logic [7:0]  m_fifo [$];
  logic [31:0] m_cnt  = 0;
  logic [31:0] m_snap = 0;
  logic        m_stop = 0;

  // Scoreboard queues
  post_t       post_q [$];
  logic        rxr_q [$];
  logic [7:0]  exp_tx [$];

  int checks = 0;
  int errors = 0;

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %02h want %02h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step(input logic s_wr, input logic [31:0] s_a, input logic [7:0] s_din,
                      input logic s_rdy, input logic s_txr, input logic s_rxv,
                      input logic [7:0] s_rxd, input logic s_rst);
    post_t      p;
    logic       e_rxr;
    logic       push;
    logic [7:0] pd;
    int         key;
    int         occ;
    @(posedge clk);
    #2;
    wr = s_wr; a = s_a; din = s_din; rdy = s_rdy; txr = s_txr;
    rxv = s_rxv; rxd = s_rxd; rst = s_rst;
    p.chk_dout = 1'b0; p.dout = 8'h00;
    e_rxr = 1'b0; push = 1'b0; pd = 8'h00;
    key = int'(s_a[16:0]);
    if (s_rst) begin
      p.chk_dout = 1'b1;
      m_cnt = 0; m_snap = 0; m_stop = 0;
      m_fifo.delete();
      exp_tx.delete();
    end else begin
      if (s_wr) begin
        if (s_a[17] == 1'b0) m_ram[key] = s_din;
        else if (s_a[16]) begin
          if (s_a[2:0] == 3'd0 && s_din != 8'h00) begin push = 1'b1; pd = s_din; end
          else if (s_a[2:0] == 3'd4) begin push = 1'b1; pd = 8'h00; m_stop = 1'b1; end
        end
      end else begin
        p.chk_dout = 1'b1;
        if (s_a[17] == 1'b0) begin
          if (m_ram.exists(key)) p.dout = m_ram[key];
          else p.chk_dout = 1'b0;
        end else if (s_a[16]) begin
          case (s_a[2:0])
            3'd0: if (s_rxv) begin p.dout = s_rxd; e_rxr = 1'b1; end
            3'd4: begin p.dout = m_cnt[7:0]; m_snap = m_cnt; end
            3'd5: p.dout = m_snap[15:8];
            3'd6: p.dout = m_snap[23:16];
            3'd7: p.dout = m_snap[31:24];
            default: p.dout = 8'h00;
          endcase
        end
      end
      occ = m_fifo.size();
      if (occ != 0 && s_txr) void'(m_fifo.pop_front());
      if (push && occ < 16) begin
        m_fifo.push_back(pd);
        exp_tx.push_back(pd);
      end
      if (s_rdy) m_cnt = m_cnt + 1;
    end
    p.full = (m_fifo.size() >= 12);
    p.txv  = (m_fifo.size() != 0);
    p.stop = m_stop;
    rxr_q.push_back(e_rxr);
    post_q.push_back(p);
  endtask

  task automatic idle(input logic s_txr, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0002_0000, 8'h00, 1'b1, s_txr, 1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: outputs of edge k-1 and combinational outputs of cycle k, mid-cycle k
  always @(negedge clk) begin
    post_t p;
    if (rxr_q.size() > 0) check8("rx_ready", {7'd0, rxr}, {7'd0, rxr_q.pop_front()});
    if (post_q.size() >= 2) begin
      p = post_q.pop_front();
      if (p.chk_dout) check8("mem_dout", dout, p.dout);
      check8("io_buffer_full", {7'd0, full}, {7'd0, p.full});
      check8("tx_valid", {7'd0, txv}, {7'd0, p.txv});
      check8("program_stop", {7'd0, stop}, {7'd0, p.stop});
    end
    if (txv === 1'b1 && txr === 1'b1) begin
      if (exp_tx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_pop got %02h want none at %0t", txd, $time);
      end else check8("tx_data", txd, exp_tx.pop_front());
    end
  end

  initial begin
    logic        r_wr, r_rst, r_txr, r_rxv, r_rdy;
    logic [31:0] r_a;
    logic [7:0]  r_din;
    int          sel;
    step(1'b0, 32'h0002_0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 32'h0002_0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // RAM write/read-back and the hole
    step(1'b1, 32'h0000_0010, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 32'h0000_0010, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 32'h0002_0010, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 32'h0002_0010, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle(1'b0, 1);

    // "Hi\0" then drain
    step(1'b1, 32'h0003_0000, 8'h48, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 32'h0003_0000, 8'h69, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 32'h0003_0000, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 4);

    // Fill past full, program stop while full, reset mid-drain
    for (int i = 0; i < 17; i++)
      step(1'b1, 32'h0003_0000, 8'(i + 1), 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 32'h0003_0004, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 5);
    step(1'b0, 32'h0002_0000, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 32'h0000_0010, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle(1'b0, 1);

    // Counter snapshot coherence
    step(1'b0, 32'h0002_0000, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    idle(1'b0, 511);
    step(1'b0, 32'h0003_0004, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle(1'b0, 3);
    step(1'b0, 32'h0003_0005, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 32'h0003_0006, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // RX pop with and without data
    step(1'b0, 32'h0003_0000, 8'h00, 1'b1, 1'b0, 1'b1, 8'h37, 1'b0);
    step(1'b0, 32'h0003_0000, 8'h00, 1'b1, 1'b0, 1'b0, 8'h99, 1'b0);
    idle(1'b0, 1);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      sel   = $urandom_range(0, 9);
      r_rst = ($urandom_range(0, 149) == 0);
      r_wr  = 1'($urandom_range(0, 1));
      r_din = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom());
      r_txr = r_rst ? 1'b0 : 1'($urandom_range(0, 2) == 0);
      r_rxv = 1'($urandom_range(0, 1));
      r_rdy = 1'($urandom_range(0, 3) != 0);
      if (sel < 4)
        r_a = ($urandom_range(0, 1) ? 32'h0001_0000 : 32'h0000_0010) + 32'($urandom_range(0, 7));
      else if (sel == 4)
        r_a = 32'h0002_0000 | 32'($urandom_range(0, 65535));
      else
        r_a = 32'h0003_0000 | (32'($urandom_range(0, 8191)) << 3) | 32'($urandom_range(0, 7));
      r_a = r_a | ($urandom() & 32'hFFFC_0000);
      step(r_wr, r_a, r_din, r_rdy, r_txr, r_rxv, 8'($urandom()), r_rst);
    end

    idle(1'b0, 3);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
